data_io_bridge: RTL and testbench

//  Sits directly downstream of the CPU data port (dataOut/dataWrEn/dataAddress/dataIn) and decodes its 14-bit word address.
//  Low region passes through to data RAM; top page maps an LED register, synchronised switches, cycle counter and UART TX with FIFO.

---
 rtl/data_io_bridge.sv | 216 +++++++++++++++++++++
 tb/tb_data_io_bridge.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_io_bridge.sv
// Data-port bridge: decodes the CPU word address into RAM or the I/O page.
// I/O page holds LEDs, synchronised switches, a cycle counter and a UART TX.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   dataAddress       14-bit word address from the CPU
//   dataOut/dataWrEn  CPU write data and single-cycle write strobe
//   dataIn            combinational read data back to the CPU
//   ramAddress/ramDataOut/ramWrEn/ramDataIn  data RAM pass-through
//   switches          asynchronous board switches
//   leds              LED register
//   uartTx            serial output, idle high
module data_io_bridge #(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] dataAddress,
    input  logic [31:0] dataOut,
    input  logic        dataWrEn,
    output logic [31:0] dataIn,
    output logic [13:0] ramAddress,
    output logic [31:0] ramDataOut,
    output logic        ramWrEn,
    input  logic [31:0] ramDataIn,
    input  logic [7:0]  switches,
    output logic [7:0]  leds,
    output logic        uartTx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // The whole 3Fxx page is I/O; everything below it is RAM.
    logic w_io;
    logic w_wr_led;
    logic w_wr_dat;
    logic w_wr_sts;

    assign w_io     = &dataAddress[13:8];
    assign w_wr_led = dataWrEn && w_io && (dataAddress[7:0] == 8'h00);
    assign w_wr_dat = dataWrEn && w_io && (dataAddress[7:0] == 8'h02);
    assign w_wr_sts = dataWrEn && w_io && (dataAddress[7:0] == 8'h03);

    assign ramAddress = dataAddress;
    assign ramDataOut = dataOut;
    assign ramWrEn    = dataWrEn && !w_io;

    logic [7:0]  r_led;
    logic [7:0]  r_sw1;
    logic [7:0]  r_sw2;
    logic [31:0] r_cycle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led   <= '0;
            r_sw1   <= '0;
            r_sw2   <= '0;
            r_cycle <= '0;
        end else begin
            r_sw1   <= switches;
            r_sw2   <= r_sw1;
            r_cycle <= r_cycle + 32'd1;
            if (w_wr_led) begin
                r_led <= dataOut[7:0];
            end
        end
    end

    assign leds = r_led;

    // TX FIFO: pointers carry an extra wrap bit to tell full from empty.
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        r_ovf;
    state_t      r_state;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_ovf_set;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    // A pop on the same edge frees a slot, so a write to a full FIFO
    // still lands when the transmitter is taking a byte.
    assign w_push    = w_wr_dat && (!w_full || w_pop);
    assign w_ovf_set = w_wr_dat && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= dataOut[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_wr_sts && dataOut[3]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // UART transmitter; uartTx is a registered FSM output.
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          w_baud_end;

    assign w_baud_end = (r_baud == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_shift <= r_mem[r_rptr[AW-1:0]];
                        r_bit   <= '0;
                        r_baud  <= '0;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign uartTx = r_tx;

    logic [31:0] w_status;

    assign w_status = {28'd0, r_ovf, (r_state != S_IDLE), w_full, w_empty};

    always_comb begin
        dataIn = '0;
        if (!w_io) begin
            dataIn = ramDataIn;
        end else begin
            case (dataAddress[7:0])
                8'h00:   dataIn = {24'd0, r_led};
                8'h01:   dataIn = {24'd0, r_sw2};
                8'h03:   dataIn = w_status;
                8'h04:   dataIn = r_cycle;
                default: dataIn = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_io_bridge.sv
// Directed testbench for data_io_bridge (BAUD_DIV=4, FIFO_DEPTH=8).
// Expected values are hand-computed constants.
module tb_data_io_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] dataAddress;
    logic [31:0] dataOut;
    logic        dataWrEn;
    logic [31:0] dataIn;
    logic [13:0] ramAddress;
    logic [31:0] ramDataOut;
    logic        ramWrEn;
    logic [31:0] ramDataIn;
    logic [7:0]  switches;
    logic [7:0]  leds;
    logic        uartTx;

    int n_chk  = 0;
    int n_pass = 0;

    data_io_bridge #(
        .BAUD_DIV   (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dataAddress (dataAddress),
        .dataOut     (dataOut),
        .dataWrEn    (dataWrEn),
        .dataIn      (dataIn),
        .ramAddress  (ramAddress),
        .ramDataOut  (ramDataOut),
        .ramWrEn     (ramWrEn),
        .ramDataIn   (ramDataIn),
        .switches    (switches),
        .leds        (leds),
        .uartTx      (uartTx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        dataAddress = a;
        dataOut     = d;
        dataWrEn    = 1'b1;
        tick();
        dataWrEn    = 1'b0;
    endtask

    task automatic rd(input logic [13:0] a, output logic [31:0] d);
        dataAddress = a;
        #1;
        d = dataIn;
    endtask

    // Samples each bit in the middle of its 4-clock slot.
    task automatic rx_byte(output logic [7:0] b, output logic ok);
        int n;
        n  = 0;
        ok = 1'b0;
        b  = '0;
        while (uartTx !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        if (uartTx === 1'b0) begin
            ok = 1'b1;
            repeat (2) tick();
            if (uartTx !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (4) tick();
                b[i] = uartTx;
            end
            repeat (4) tick();
            if (uartTx !== 1'b1) ok = 1'b0;
        end
    endtask

    logic [31:0] v;
    logic [7:0]  rb;
    logic        ok;
    logic [9:0]  frame;
    int          lows;

    initial begin
        rst         = 1'b1;
        dataAddress = '0;
        dataOut     = '0;
        dataWrEn    = 1'b0;
        ramDataIn   = 32'hDEAD_BEEF;
        switches    = 8'h81;
        frame       = {1'b1, 8'h41, 1'b0};

        // Reset state
        repeat (3) tick();
        check("rst_tx", {31'd0, uartTx}, 32'd1);
        check("rst_leds", {24'd0, leds}, 32'd0);
        rd(14'h3F03, v);
        check("rst_status", v, 32'h1);
        rd(14'h3F01, v);
        check("rst_sw", v, 32'h0);
        rd(14'h3F04, v);
        check("rst_cycle", v, 32'h0);
        dataAddress = 14'h0000;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Cycle counter and idle status
        repeat (100) tick();
        rd(14'h3F04, v);
        check("cycle_100", v, 32'd100);
        rd(14'h3F03, v);
        check("status_idle", v, 32'h1);
        rd(14'h3F01, v);
        check("sw_init", v, 32'h81);

        // LED register and RAM pass-through
        wr(14'h3F00, 32'h1234_56A5);
        check("leds_wr", {24'd0, leds}, 32'hA5);
        rd(14'h3F00, v);
        check("led_rd", v, 32'hA5);
        dataAddress = 14'h0100;
        dataOut     = 32'h55;
        dataWrEn    = 1'b1;
        #1;
        check("ram_we", {31'd0, ramWrEn}, 32'd1);
        check("ram_addr", {18'd0, ramAddress}, 32'h0100);
        check("ram_dout", ramDataOut, 32'h55);
        check("ram_rd", dataIn, 32'hDEAD_BEEF);
        dataAddress = 14'h3EFF;
        #1;
        check("ram_we_3eff", {31'd0, ramWrEn}, 32'd1);
        dataAddress = 14'h3F00;
        #1;
        check("ram_we_3f00", {31'd0, ramWrEn}, 32'd0);
        dataAddress = 14'h0100;
        tick();
        dataWrEn = 1'b0;
        check("leds_keep", {24'd0, leds}, 32'hA5);
        wr(14'h3F05, 32'h77);
        check("leds_unmapped", {24'd0, leds}, 32'hA5);
        rd(14'h3F05, v);
        check("rd_3f05", v, 32'h0);
        rd(14'h3F02, v);
        check("rd_uart_wo", v, 32'h0);
        rd(14'h3FFF, v);
        check("rd_3fff", v, 32'h0);

        // Switch synchroniser latency
        switches    = 8'h3C;
        dataAddress = 14'h3F01;
        #1;
        check("sw_lat0", dataIn, 32'h81);
        tick();
        check("sw_lat1", dataIn, 32'h81);
        tick();
        check("sw_lat2", dataIn, 32'h3C);

        // Single UART frame of 0x41
        wr(14'h3F02, 32'h41);
        rd(14'h3F03, v);
        check("st_queued", v, 32'h0);
        for (int k = 0; k < 40; k++) begin
            tick();
            check($sformatf("tx_bit%0d", k), {31'd0, uartTx},
                  {31'd0, frame[k/4]});
            check($sformatf("busy%0d", k), {31'd0, dataIn[2]}, 32'd1);
        end
        tick();
        check("tx_idle", {31'd0, uartTx}, 32'd1);
        check("st_done", dataIn, 32'h1);

        // Ten back-to-back writes: one popped, eight queued, one dropped
        dataAddress = 14'h3F02;
        dataWrEn    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            dataOut = (i == 0) ? 32'hFF : 32'hA0 + i;
            tick();
        end
        dataWrEn = 1'b0;
        rd(14'h3F03, v);
        check("st_ovf", v, 32'hE);

        // Status write without bit 3 keeps overflow; with bit 3 clears it
        wr(14'h3F03, 32'h7);
        rd(14'h3F03, v);
        check("ovf_keep", v, 32'hE);
        wr(14'h3F03, 32'h8);
        rd(14'h3F03, v);
        check("ovf_clr", v, 32'h6);

        // Write into the full FIFO on the edge the idle FSM pops
        repeat (30) tick();
        wr(14'h3F02, 32'hBB);
        rd(14'h3F03, v);
        check("push_on_pop", v, 32'h6);

        // Frame order
        rx_byte(rb, ok);
        check("rx1_ok", {31'd0, ok}, 32'd1);
        check("rx1_byte", {24'd0, rb}, 32'hA1);
        rx_byte(rb, ok);
        check("rx2_ok", {31'd0, ok}, 32'd1);
        check("rx2_byte", {24'd0, rb}, 32'hA2);

        // Reset in the middle of a start bit
        lows = 0;
        while (uartTx !== 1'b0 && lows < 100) begin
            tick();
            lows++;
        end
        check("pre_rst_low", {31'd0, uartTx}, 32'd0);
        dataAddress = 14'h3F03;
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_tx", {31'd0, uartTx}, 32'd1);
        check("rst_mid_st", dataIn, 32'h1);
        check("rst_mid_led", {24'd0, leds}, 32'h0);
        tick();
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (uartTx !== 1'b1) lows++;
        end
        check("post_rst_quiet", lows, 32'd0);
        check("post_rst_st", dataIn, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
